// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bram_port_arbiter
// Brief   : Burst-granular round-robin share of one BRAM port (ingest writes / fetch reads).
// Revision: 1.0
// ============================================================================
module bram_port_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 128,
  parameter int RD_LAT    = 1,
  parameter int MAX_BEATS = 256
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [1:0]            req_i,
  output logic [1:0]            gnt_o,
  input  logic [1:0]            vld_i,
  input  logic [1:0]            last_i,
  input  logic [DATA_W/8-1:0]   we0_i,
  input  logic [ADDR_W-1:0]     addr0_i,
  input  logic [DATA_W-1:0]     wdata0_i,
  input  logic [ADDR_W-1:0]     addr1_i,
  output logic [DATA_W-1:0]     rdata1_o,
  output logic                  rvld1_o,
  output logic                  bram_clk,
  output logic                  bram_rst,
  output logic                  bram_en,
  output logic [DATA_W/8-1:0]   bram_we,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic [DATA_W-1:0]     bram_dout,
  input  logic [DATA_W-1:0]     bram_din,
  output logic                  data_inserted,
  output logic                  wdog_err
);

  localparam int       c_STRB_W = DATA_W / 8;
  localparam bit [8:0] c_TC     = 9'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_G0   = 2'd1,
    S_G1   = 2'd2,
    S_TURN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rr_ptr;
  logic [8:0]        r_beat_cnt;
  logic              r_data_ins;
  logic              r_wdog_err;
  logic [RD_LAT-1:0] r_rd_pipe;

  logic              w_beat;
  logic              w_last;
  logic              w_tc;
  logic              w_rd_beat;

  // Beat qualification and next-state decode
  always_comb begin
    w_state_nxt = r_state;
    w_beat      = 1'b0;
    w_last      = 1'b0;
    w_tc        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_i == 2'b11)
          w_state_nxt = r_rr_ptr ? S_G1 : S_G0;
        else if (req_i[0])
          w_state_nxt = S_G0;
        else if (req_i[1])
          w_state_nxt = S_G1;
      end
      S_G0, S_G1: begin
        w_beat = (r_state == S_G0) ? vld_i[0] : vld_i[1];
        w_last = w_beat & ((r_state == S_G0) ? last_i[0] : last_i[1]);
        // A last beat landing on the terminal count is an ordinary completion
        w_tc   = w_beat & ~w_last & (r_beat_cnt == c_TC);
        if (w_last || w_tc)
          w_state_nxt = S_TURN;
      end
      S_TURN: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= 1'b0;
      r_beat_cnt <= '0;
      r_data_ins <= 1'b0;
      r_wdog_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE)
        r_beat_cnt <= '0;
      else if (w_beat)
        r_beat_cnt <= r_beat_cnt + 9'd1;
      // Priority passes to the other requester after any release
      if (w_last || w_tc)
        r_rr_ptr <= (r_state == S_G0);
      r_data_ins <= (w_last || w_tc) && (r_state == S_G0);
      if (w_tc)
        r_wdog_err <= 1'b1;
    end
  end

  assign w_rd_beat = (r_state == S_G1) && vld_i[1];

  generate
    if (RD_LAT == 1) begin : g_pipe_lat1
      always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN)
          r_rd_pipe <= '0;
        else
          r_rd_pipe <= w_rd_beat;
      end
    end else begin : g_pipe_shift
      always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN)
          r_rd_pipe <= '0;
        else
          r_rd_pipe <= {r_rd_pipe[RD_LAT-2:0], w_rd_beat};
      end
    end
  endgenerate

  // BRAM port mux; idle and turnaround states leave the port quiet
  always_comb begin
    bram_en   = 1'b0;
    bram_we   = '0;
    bram_addr = '0;
    bram_dout = '0;
    case (r_state)
      S_G0: begin
        bram_en   = vld_i[0];
        bram_we   = vld_i[0] ? we0_i : {c_STRB_W{1'b0}};
        bram_addr = addr0_i;
        bram_dout = wdata0_i;
      end
      S_G1: begin
        bram_en   = vld_i[1];
        bram_addr = addr1_i;
      end
      default: ;
    endcase
  end

  assign gnt_o         = {r_state == S_G1, r_state == S_G0};
  assign rvld1_o       = r_rd_pipe[RD_LAT-1];
  assign rdata1_o      = bram_din;
  assign bram_clk      = S_AXI_ACLK;
  assign bram_rst      = ~S_AXI_ARESETN;
  assign data_inserted = r_data_ins;
  assign wdog_err      = r_wdog_err;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bram_port_arbiter
// Brief   : Directed bench for bram_port_arbiter with a 2-cycle BRAM model.
// Revision: 1.0
// ============================================================================
module tb_bram_port_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 128;
  localparam int STRB_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic [1:0]        req, vld, last;
  logic [1:0]        gnt;
  logic [STRB_W-1:0] we0;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, rdata1;
  logic              rvld1, bclk, brst, ben;
  logic [STRB_W-1:0] bwe;
  logic [ADDR_W-1:0] baddr;
  logic [DATA_W-1:0] bdout, bdin;
  logic              dins, wdog;

  int checks = 0;
  int errors = 0;

  localparam logic [STRB_W-1:0] c_STRB = 16'hFF00;
  localparam logic [DATA_W-1:0] c_D5   = 128'h0505_0505_1111_2222_3333_4444_5555_6666;
  localparam logic [DATA_W-1:0] c_D6   = 128'h0606_0606_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;

  bram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .MAX_BEATS(4)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
    .req_i(req), .gnt_o(gnt), .vld_i(vld), .last_i(last),
    .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0), .addr1_i(addr1),
    .rdata1_o(rdata1), .rvld1_o(rvld1),
    .bram_clk(bclk), .bram_rst(brst), .bram_en(ben), .bram_we(bwe),
    .bram_addr(baddr), .bram_dout(bdout), .bram_din(bdin),
    .data_inserted(dins), .wdog_err(wdog)
  );

  always #5 clk = ~clk;

  // BRAM model: byte-strobed writes, two-stage registered read
  logic [DATA_W-1:0] mem [0:63];
  logic [DATA_W-1:0] rd_s1, rd_s2;
  always @(posedge bclk) begin
    if (ben) begin
      rd_s1 <= mem[baddr[5:0]];
      for (int b = 0; b < STRB_W; b++)
        if (bwe[b]) mem[baddr[5:0]][b*8 +: 8] <= bdout[b*8 +: 8];
    end
    rd_s2 <= rd_s1;
  end
  assign bdin = rd_s2;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] wpat(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  // Drives n beats from requester k, optionally with gap cycles carrying noise from the other requester
  task automatic burst(input int k, input int n, input logic [ADDR_W-1:0] base,
                       input bit gaps, input bit do_last);
    for (int i = 0; i < n; i++) begin
      vld = 2'b00; last = 2'b00;
      vld[k]  = 1'b1;
      last[k] = do_last && (i == n - 1);
      if (k == 0) begin
        addr0 = base + ADDR_W'(i); we0 = c_STRB; wdata0 = wpat(i);
      end else begin
        addr1 = base + ADDR_W'(i);
      end
      #1;
      chk("beat_en", 128'(ben), 128'(1));
      chk("beat_we", 128'(bwe), (k == 0) ? 128'(c_STRB) : 128'(0));
      chk("beat_addr", 128'(baddr), 128'(base + ADDR_W'(i)));
      if (k == 0) chk("beat_dout", bdout, wpat(i));
      tick();
      if (gaps && i < n - 1) begin
        vld = 2'b00; last = 2'b00;
        vld[1-k] = 1'b1;
        addr0 = 14'h3F; addr1 = 14'h3F;
        #1;
        chk("gap_en", 128'(ben), 128'(0));
        chk("gap_we", 128'(bwe), 128'(0));
        tick();
      end
    end
    vld = 2'b00; last = 2'b00;
  endtask

  initial begin
    for (int a = 0; a < 64; a++) mem[a] = '0;
    mem[5] = c_D5;
    mem[6] = c_D6;
    rstn = 1'b0; req = 2'b00; vld = 2'b00; last = 2'b00;
    we0 = '0; addr0 = '0; addr1 = '0; wdata0 = '0;
    tick(); tick();

    // Reset state
    chk("rst_gnt", 128'(gnt), 128'(0));
    chk("rst_en", 128'(ben), 128'(0));
    chk("rst_rvld", 128'(rvld1), 128'(0));
    chk("rst_dins", 128'(dins), 128'(0));
    chk("rst_wdog", 128'(wdog), 128'(0));
    chk("rst_brst", 128'(brst), 128'(1));
    rstn = 1'b1;
    tick();

    // 1. Solo 4-beat write; last coincides with the watchdog terminal count
    req = 2'b01;
    tick();
    chk("t1_gnt", 128'(gnt), 128'(2'b01));
    req = 2'b00;
    burst(0, 4, 14'h10, 1'b0, 1'b1);
    chk("t1_turn_gnt", 128'(gnt), 128'(0));
    chk("t1_dins", 128'(dins), 128'(1));
    chk("t1_turn_en", 128'(ben), 128'(0));
    chk("t1_wdog", 128'(wdog), 128'(0));
    tick();
    chk("t1_idle_dins", 128'(dins), 128'(0));
    chk("t1_idle_gnt", 128'(gnt), 128'(0));
    chk("t1_mem12", mem[6'h12], {32'hC0DE_0002, 32'hC0DE_0002, 64'h0});

    // 3. Reads at RD_LAT=2
    req = 2'b10;
    tick();
    chk("t3_gnt", 128'(gnt), 128'(2'b10));
    req = 2'b00;
    vld = 2'b10; addr1 = 14'd5; last = 2'b00;
    #1;
    chk("t3_we0", 128'(bwe), 128'(0));
    chk("t3_en0", 128'(ben), 128'(1));
    tick();
    chk("t3_rvld_early", 128'(rvld1), 128'(0));
    vld = 2'b10; addr1 = 14'd6; last = 2'b10;
    #1;
    chk("t3_we1", 128'(bwe), 128'(0));
    chk("t3_addr1", 128'(baddr), 128'(6));
    tick();
    vld = 2'b00; last = 2'b00;
    chk("t3_rvld_a", 128'(rvld1), 128'(1));
    chk("t3_rdata_a", rdata1, c_D5);
    chk("t3_turn_gnt", 128'(gnt), 128'(0));
    chk("t3_dins", 128'(dins), 128'(0));
    tick();
    chk("t3_rvld_b", 128'(rvld1), 128'(1));
    chk("t3_rdata_b", rdata1, c_D6);
    tick();
    chk("t3_rvld_end", 128'(rvld1), 128'(0));

    // 2. Contention with round-robin pointer at 0
    req = 2'b11;
    tick();
    for (int g = 0; g < 4; g++) begin
      chk("t2_gnt", 128'(gnt), (g % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
      if (g == 3) req = 2'b00;
      burst(g % 2, 2, 14'h20, 1'b0, 1'b1);
      chk("t2_turn_gnt", 128'(gnt), 128'(0));
      chk("t2_dins", 128'(dins), (g % 2 == 0) ? 128'(1) : 128'(0));
      tick();
      chk("t2_idle_gnt", 128'(gnt), 128'(0));
      tick();
    end
    chk("t2_stay_idle", 128'(gnt), 128'(0));

    // 6. Gapped beats: gaps must not advance the beat count
    req = 2'b01;
    tick();
    chk("t6_gnt", 128'(gnt), 128'(2'b01));
    req = 2'b00;
    burst(0, 4, 14'h28, 1'b1, 1'b1);
    chk("t6_dins", 128'(dins), 128'(1));
    chk("t6_wdog", 128'(wdog), 128'(0));
    chk("t6_mem2b", mem[6'h2B], {32'hC0DE_0003, 32'hC0DE_0003, 64'h0});
    tick();

    // 4. Watchdog: six beats without last, release after the fourth
    req = 2'b01;
    tick();
    chk("t4_gnt", 128'(gnt), 128'(2'b01));
    req = 2'b11;
    burst(0, 4, 14'h30, 1'b0, 1'b0);
    chk("t4_gnt_rel", 128'(gnt), 128'(0));
    chk("t4_dins", 128'(dins), 128'(1));
    chk("t4_wdog", 128'(wdog), 128'(1));
    vld = 2'b01;
    #1;
    chk("t4_beat5_en", 128'(ben), 128'(0));
    tick();
    chk("t4_idle_gnt", 128'(gnt), 128'(0));
    chk("t4_dins_end", 128'(dins), 128'(0));
    #1;
    chk("t4_beat6_en", 128'(ben), 128'(0));
    tick();
    vld = 2'b00;
    chk("t4_next_gnt", 128'(gnt), 128'(2'b10));
    chk("t4_wdog_sticky", 128'(wdog), 128'(1));

    // 5. Reset on beat 2 of a read burst
    req = 2'b00;
    vld = 2'b10; addr1 = 14'd5;
    tick();
    vld = 2'b10; addr1 = 14'd6;
    rstn = 1'b0;
    tick();
    chk("t5_gnt", 128'(gnt), 128'(0));
    chk("t5_rvld", 128'(rvld1), 128'(0));
    chk("t5_dins", 128'(dins), 128'(0));
    chk("t5_wdog", 128'(wdog), 128'(0));
    rstn = 1'b1; vld = 2'b00;
    tick();
    chk("t5_rvld_post", 128'(rvld1), 128'(0));
    req = 2'b11;
    tick();
    chk("t5_rr_reset", 128'(gnt), 128'(2'b01));
    req = 2'b00;
    burst(0, 1, 14'h38, 1'b0, 1'b1);
    chk("t5_dins_ok", 128'(dins), 128'(1));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
